// File: rtl/ct_ifu_sfp_wr_ctrl_pkg.sv
// rtl/ct_ifu_sfp_wr_ctrl_pkg.sv - SFP write controller shared types, encodings and helpers
package ct_ifu_sfp_pkg;

  typedef enum logic [1:0] {
    OP_ALLOC = 2'b00,
    OP_INC   = 2'b01,
    OP_DEC   = 2'b10,
    OP_CLR   = 2'b11
  } req_op_e;

  localparam logic [3:0] CNT_SET = 4'b0010;
  localparam logic [3:0] CNT_INC = 4'b0100;
  localparam logic [3:0] CNT_DEC = 4'b0001;
  localparam logic [3:0] CNT_CLR = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_WR_SF  = 2'b01,
    ST_WR_BAR = 2'b10,
    ST_WR_CNT = 2'b11
  } state_e;

  localparam int WD_W      = 25;
  localparam int WD_TYPE   = 24;
  localparam int WD_HI_LSB = 16;
  localparam int WD_PC_LSB = 4;

  function automatic logic [3:0] cnt_op_of(input logic [1:0] op);
    case (op)
      OP_INC:  return CNT_INC;
      OP_DEC:  return CNT_DEC;
      OP_CLR:  return CNT_CLR;
      default: return CNT_SET;
    endcase
  endfunction

  function automatic logic [WD_W-1:0] pack_wd(input logic typ, input logic [7:0] hi,
                                              input logic [11:0] pc, input logic [3:0] cop);
    logic [WD_W-1:0] w;
    w = '0;
    w[WD_TYPE] = typ;
    w[WD_HI_LSB +: 8] = hi;
    w[WD_PC_LSB +: 12] = pc;
    w[3:0] = cop;
    return w;
  endfunction

endpackage

// File: rtl/ct_ifu_sfp_wr_ctrl_if.sv
// rtl/ct_ifu_sfp_wr_ctrl_if.sv - SFP training request channel
interface ct_ifu_sfp_wr_ctrl_if;
  logic        req_vld;
  logic        req_rdy;
  logic [1:0]  req_op;
  logic        req_type;
  logic [7:0]  req_hi_pc;
  logic [11:0] req_sf_pc;
  logic [11:0] req_bar_pc;

  modport master (output req_vld, req_op, req_type, req_hi_pc, req_sf_pc, req_bar_pc,
                  input  req_rdy);
  modport slave  (input  req_vld, req_op, req_type, req_hi_pc, req_sf_pc, req_bar_pc,
                  output req_rdy);
endinterface

// File: rtl/ct_ifu_sfp_wr_ctrl_victim_sel.sv
// rtl/ct_ifu_sfp_wr_ctrl_victim_sel.sv - ALLOC victim pick: lowest invalid, else lowest cnt==0, else round-robin
module ct_ifu_sfp_victim_sel #(
  parameter int ENTRY_NUM = 8,
  parameter int IDX_W     = $clog2(ENTRY_NUM)
) (
  input  logic [ENTRY_NUM-1:0]   valid,
  input  logic [2*ENTRY_NUM-1:0] cnt,
  input  logic [IDX_W-1:0]       rr_ptr,
  output logic [IDX_W-1:0]       victim_idx,
  output logic                   rr_advance
);

  logic             found_inv;
  logic             found_zero;
  logic [IDX_W-1:0] inv_idx;
  logic [IDX_W-1:0] zero_idx;

  // Scanning downward leaves the lowest qualifying index in place.
  always_comb begin
    found_inv  = 1'b0;
    found_zero = 1'b0;
    inv_idx    = '0;
    zero_idx   = '0;
    for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        found_inv = 1'b1;
        inv_idx   = IDX_W'(i);
      end
      if (cnt[2*i +: 2] == 2'b00) begin
        found_zero = 1'b1;
        zero_idx   = IDX_W'(i);
      end
    end
    rr_advance = !found_inv && !found_zero;
    victim_idx = found_inv ? inv_idx : (found_zero ? zero_idx : rr_ptr);
  end

endmodule

// File: rtl/ct_ifu_sfp_wr_ctrl.sv
// rtl/ct_ifu_sfp_wr_ctrl.sv - SFP table write controller: resolves training requests to one entry
module ct_ifu_sfp_wr_ctrl
  import ct_ifu_sfp_pkg::*;
#(
  parameter int ENTRY_NUM = 8
) (
  input  logic                     sfp_entry_clk,
  input  logic                     cpurst_b,
  input  logic                     cp0_ifu_nsfe,
  input  logic                     sfp_vl_pred_en,
  ct_ifu_sfp_wr_ctrl_if.slave      req,
  input  logic [8*ENTRY_NUM-1:0]   entry_hi_pc_v,
  input  logic [12*ENTRY_NUM-1:0]  entry_sf_pc_v,
  input  logic [2*ENTRY_NUM-1:0]   entry_cnt_v,
  input  logic [ENTRY_NUM-1:0]     entry_type_v,
  output logic [ENTRY_NUM-1:0]     entry_write_en_x,
  output logic [ENTRY_NUM-1:0]     entry_clk_en_x,
  output logic [WD_W-1:0]          entry_write_data,
  output logic                     entry_sf_pc_updt_bit,
  output logic                     entry_bar_pc_updt_bit,
  output logic                     entry_cnt_updt_bit,
  output logic                     sfp_updt_miss
);

  localparam int IDX_W = $clog2(ENTRY_NUM);

  state_e               state, state_nxt;
  logic [ENTRY_NUM-1:0] valid;
  logic [IDX_W-1:0]     rr_ptr;
  logic [1:0]           q_op;
  logic                 q_type;
  logic [7:0]           q_hi_pc;
  logic [11:0]          q_sf_pc;
  logic [11:0]          q_bar_pc;
  logic [IDX_W-1:0]     q_tgt;
  logic                 miss_q;

  logic                 en;
  logic [ENTRY_NUM-1:0] hit;
  logic                 hit_any;
  logic [IDX_W-1:0]     hit_idx;
  logic [IDX_W-1:0]     victim_idx;
  logic                 rr_advance;
  logic [IDX_W-1:0]     sel_idx;
  logic                 accept;
  logic                 is_alloc;
  logic                 go_wr;

  assign en       = cp0_ifu_nsfe | sfp_vl_pred_en;
  assign is_alloc = (req.req_op == OP_ALLOC);
  // With SFP disabled the channel keeps draining so upstream never stalls.
  assign req.req_rdy = (state == ST_IDLE) | ~en;
  assign accept   = req.req_vld & (state == ST_IDLE) & en;

  always_comb begin
    hit     = '0;
    hit_idx = '0;
    for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
      hit[i] = valid[i] & (entry_hi_pc_v[8*i +: 8] == req.req_hi_pc)
                        & (entry_sf_pc_v[12*i +: 12] == req.req_sf_pc);
      if (hit[i]) hit_idx = IDX_W'(i);
    end
    hit_any = |hit;
  end

  ct_ifu_sfp_victim_sel #(.ENTRY_NUM(ENTRY_NUM), .IDX_W(IDX_W)) u_victim_sel (
    .valid      (valid),
    .cnt        (entry_cnt_v),
    .rr_ptr     (rr_ptr),
    .victim_idx (victim_idx),
    .rr_advance (rr_advance)
  );

  assign sel_idx = hit_any ? hit_idx : victim_idx;
  assign go_wr   = accept & (is_alloc | hit_any);

  always_ff @(posedge sfp_entry_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state    <= ST_IDLE;
      valid    <= '0;
      rr_ptr   <= '0;
      q_op     <= '0;
      q_type   <= 1'b0;
      q_hi_pc  <= '0;
      q_sf_pc  <= '0;
      q_bar_pc <= '0;
      q_tgt    <= '0;
      miss_q   <= 1'b0;
    end else begin
      state  <= state_nxt;
      miss_q <= accept & ~is_alloc & ~hit_any;
      if (go_wr) begin
        q_op     <= req.req_op;
        q_type   <= req.req_type;
        q_hi_pc  <= req.req_hi_pc;
        q_sf_pc  <= req.req_sf_pc;
        q_bar_pc <= req.req_bar_pc;
        q_tgt    <= sel_idx;
      end
      if (accept && is_alloc) begin
        valid[sel_idx] <= 1'b1;
        if (!hit_any && rr_advance) rr_ptr <= rr_ptr + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt             = state;
    entry_write_en_x      = '0;
    entry_write_data      = '0;
    entry_sf_pc_updt_bit  = 1'b0;
    entry_bar_pc_updt_bit = 1'b0;
    entry_cnt_updt_bit    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (go_wr) state_nxt = is_alloc ? ST_WR_SF : ST_WR_CNT;
      end
      ST_WR_SF: begin
        entry_write_en_x     = ENTRY_NUM'(1) << q_tgt;
        entry_write_data     = pack_wd(q_type, q_hi_pc, q_sf_pc, CNT_SET);
        entry_sf_pc_updt_bit = 1'b1;
        entry_cnt_updt_bit   = 1'b1;
        state_nxt            = ST_WR_BAR;
      end
      ST_WR_BAR: begin
        entry_write_en_x      = ENTRY_NUM'(1) << q_tgt;
        entry_write_data      = pack_wd(q_type, q_hi_pc, q_bar_pc, 4'b0000);
        entry_bar_pc_updt_bit = 1'b1;
        state_nxt             = ST_IDLE;
      end
      ST_WR_CNT: begin
        entry_write_en_x   = ENTRY_NUM'(1) << q_tgt;
        entry_write_data   = pack_wd(entry_type_v[q_tgt], q_hi_pc, q_sf_pc, cnt_op_of(q_op));
        entry_cnt_updt_bit = 1'b1;
        state_nxt          = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign entry_clk_en_x = entry_write_en_x;
  assign sfp_updt_miss  = miss_q;

endmodule
